// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command decoder:
// opcode constants and the decoder FSM state type.
package spi_cmd_pkg;

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_CTRL  = 8'h02;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    DATA,
    CTRL_DATA,
    DISCARD
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with a
// configurable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops to settle metastability
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_cmd_decoder.sv
// SPI byte-stream command decoder driving a
// framebuffer write port and a control register.
module spi_cmd_decoder
  import spi_cmd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              d_valid,
  input  logic [WIDTH-1:0]  dout,
  output logic [WIDTH-1:0]  din,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [WIDTH-1:0]  fb_wdata,
  output logic [WIDTH-1:0]  ctrl_reg,
  output logic              cmd_err
);

  localparam int HI_W = ADDR_W - 8;

  logic              dv_s;
  logic              cs_s;
  logic              dv_d;
  logic              cs_d;
  logic [1:0]        settle;
  logic              armed;
  logic              byte_stb;
  logic              cs_rise;
  logic [WIDTH-1:0]  byte_q;
  logic [ADDR_W-1:0] addr;
  state_t            state;

  sync_2ff #(.RST_VAL(1'b0)) u_sync_dv (
    .clk (clk),
    .rst (rst),
    .d   (d_valid),
    .q   (dv_s)
  );

  sync_2ff #(.RST_VAL(1'b1)) u_sync_cs (
    .clk (clk),
    .rst (rst),
    .d   (cs_n),
    .q   (cs_s)
  );

  assign din = ctrl_reg;

  // Edge detection; armed only once cs_n is
  // really seen high, so a packet cut by reset
  // is ignored until the next falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      dv_d     <= 1'b0;
      cs_d     <= 1'b1;
      settle   <= 2'b00;
      armed    <= 1'b0;
      byte_stb <= 1'b0;
      cs_rise  <= 1'b0;
      byte_q   <= '0;
    end else begin
      dv_d     <= dv_s;
      cs_d     <= cs_s;
      settle   <= {settle[0], 1'b1};
      if (settle[1] && cs_s)
        armed <= 1'b1;
      byte_stb <= dv_s && !dv_d
                  && !cs_d && armed;
      cs_rise  <= cs_s && !cs_d;
      if (dv_s && !dv_d)
        byte_q <= dout;
    end
  end

  // Command FSM with registered outputs; a
  // cs_n rise is applied after the byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fb_we    <= 1'b0;
      fb_addr  <= '0;
      fb_wdata <= '0;
      ctrl_reg <= '0;
      cmd_err  <= 1'b0;
      addr     <= '0;
    end else begin
      fb_we <= 1'b0;
      if (byte_stb) begin
        unique case (state)
          IDLE: begin
            if (byte_q == WIDTH'(OP_WRITE)) begin
              state <= ADDR_HI;
            end else if (byte_q == WIDTH'(OP_CTRL)) begin
              state <= CTRL_DATA;
            end else begin
              cmd_err <= 1'b1;
              state   <= DISCARD;
            end
          end
          ADDR_HI: begin
            addr[ADDR_W-1:8] <= HI_W'(byte_q);
            state <= ADDR_LO;
          end
          ADDR_LO: begin
            addr[7:0] <= 8'(byte_q);
            state <= DATA;
          end
          DATA: begin
            fb_we    <= 1'b1;
            fb_addr  <= addr;
            fb_wdata <= byte_q;
            addr     <= addr + ADDR_W'(1);
          end
          CTRL_DATA: begin
            ctrl_reg <= byte_q;
            cmd_err  <= 1'b0;
            state    <= DISCARD;
          end
          DISCARD: begin
            state <= DISCARD;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
      if (cs_rise)
        state <= IDLE;
    end
  end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Self-checking bench for spi_cmd_decoder:
// directed table, corner sequences, random packets.
module tb_spi_cmd_decoder;

  localparam int WIDTH  = 8;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              cs_n;
  logic              d_valid;
  logic [WIDTH-1:0]  dout;
  logic [WIDTH-1:0]  din;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic [WIDTH-1:0]  fb_wdata;
  logic [WIDTH-1:0]  ctrl_reg;
  logic              cmd_err;

  spi_cmd_decoder #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cs_n     (cs_n),
    .d_valid  (d_valid),
    .dout     (dout),
    .din      (din),
    .fb_we    (fb_we),
    .fb_addr  (fb_addr),
    .fb_wdata (fb_wdata),
    .ctrl_reg (ctrl_reg),
    .cmd_err  (cmd_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    int a;
    int d;
    int c;
  } wr_t;

  wr_t exp_q[$];
  wr_t got_q[$];

  always @(negedge clk)
    if (fb_we === 1'b1)
      got_q.push_back('{int'(fb_addr),
                       int'(fb_wdata), cyc});

  int checks = 0;
  int errors = 0;

  int ctrl_m = 0;
  int err_m  = 0;
  int la_m   = 0;
  int ld_m   = 0;

  logic [7:0] pkt [16];
  int plen;

  typedef struct {
    int          n;
    logic [47:0] b;
    int          nw;
    int          a0;
    int          d0;
    int          ctrl;
    int          err;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic send_byte(input logic [7:0] b,
                           output int sc);
    @(negedge clk);
    dout    = b;
    d_valid = 1'b1;
    sc      = cyc + 1;
    repeat (4) @(negedge clk);
    d_valid = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic run_packet();
    int wa [16];
    int wd [16];
    bit isw [16];
    int base;
    int sc;
    for (int i = 0; i < 16; i++) isw[i] = 0;
    if (plen > 0) begin
      if (pkt[0] == 8'h01) begin
        if (plen >= 4) begin
          base = int'(pkt[1]) * 256 + int'(pkt[2]);
          for (int i = 3; i < plen; i++) begin
            isw[i] = 1;
            wa[i]  = (base + i - 3) % 65536;
            wd[i]  = int'(pkt[i]);
          end
        end
      end else if (pkt[0] == 8'h02) begin
        if (plen >= 2) begin
          ctrl_m = int'(pkt[1]);
          err_m  = 0;
        end
      end else begin
        err_m = 1;
      end
    end
    @(negedge clk);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < plen; i++) begin
      send_byte(pkt[i], sc);
      if (isw[i]) begin
        exp_q.push_back('{wa[i], wd[i], sc + 3});
        la_m = wa[i];
        ld_m = wd[i];
      end
    end
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic compare_writes(input string tag);
    int n;
    chk({tag, "_nwr"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size())
        ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_waddr"}, got_q[i].a, exp_q[i].a);
      chk({tag, "_wdata"}, got_q[i].d, exp_q[i].d);
      chk({tag, "_wcyc"},  got_q[i].c, exp_q[i].c);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_ctrl"},  ctrl_reg, ctrl_m);
    chk({tag, "_din"},   din,      ctrl_m);
    chk({tag, "_err"},   cmd_err,  err_m);
    chk({tag, "_addr"},  fb_addr,  la_m);
    chk({tag, "_wdat"},  fb_wdata, ld_m);
    chk({tag, "_we"},    fb_we,    0);
  endtask

  initial begin
    int sc;
    int sel;

    tbl[0] = '{6, 48'h01_12_34_AA_BB_CC,
               3, 'h1234, 'hAA, 'h00, 0};
    tbl[1] = '{5, 48'h01_FF_FF_11_22_00,
               2, 'hFFFF, 'h11, 'h00, 0};
    tbl[2] = '{3, 48'h02_5A_77_00_00_00,
               0, 0, 0, 'h5A, 0};
    tbl[3] = '{5, 48'h7E_01_00_00_33_00,
               0, 0, 0, 'h5A, 1};
    tbl[4] = '{2, 48'h02_00_00_00_00_00,
               0, 0, 0, 'h00, 0};
    tbl[5] = '{2, 48'h01_00_00_00_00_00,
               0, 0, 0, 'h00, 0};
    tbl[6] = '{4, 48'h01_00_10_44_00_00,
               1, 'h0010, 'h44, 'h00, 0};

    rst     = 1'b1;
    cs_n    = 1'b1;
    d_valid = 1'b0;
    dout    = '0;
    repeat (3) @(negedge clk);
    check_regs("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int k = 0; k < 7; k++) begin
      plen = tbl[k].n;
      for (int i = 0; i < plen; i++)
        pkt[i] = tbl[k].b[47 - 8*i -: 8];
      run_packet();
      chk("tbl_nwr", got_q.size(), tbl[k].nw);
      if (tbl[k].nw > 0 && got_q.size() > 0) begin
        chk("tbl_a0", got_q[0].a, tbl[k].a0);
        chk("tbl_d0", got_q[0].d, tbl[k].d0);
      end
      chk("tbl_ctrl", ctrl_reg, tbl[k].ctrl);
      chk("tbl_err",  cmd_err,  tbl[k].err);
      compare_writes("tbl");
      check_regs("tbl");
    end

    // byte strobe and cs_n rise in the same cycle
    @(negedge clk);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    send_byte(8'h01, sc);
    send_byte(8'h20, sc);
    send_byte(8'h00, sc);
    @(negedge clk);
    dout    = 8'h55;
    d_valid = 1'b1;
    cs_n    = 1'b1;
    sc      = cyc + 1;
    exp_q.push_back('{'h2000, 'h55, sc + 3});
    la_m = 'h2000;
    ld_m = 'h55;
    repeat (4) @(negedge clk);
    d_valid = 1'b0;
    repeat (8) @(negedge clk);
    compare_writes("csrise");
    plen   = 2;
    pkt[0] = 8'h02;
    pkt[1] = 8'h33;
    run_packet();
    chk("csrise_idle_ctrl", ctrl_reg, 'h33);
    compare_writes("csrise2");
    check_regs("csrise2");

    // reset in the middle of a packet
    @(negedge clk);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    send_byte(8'h01, sc);
    send_byte(8'h12, sc);
    send_byte(8'h34, sc);
    send_byte(8'hAA, sc);
    exp_q.push_back('{'h1234, 'hAA, sc + 3});
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    ctrl_m = 0;
    err_m  = 0;
    la_m   = 0;
    ld_m   = 0;
    send_byte(8'hBB, sc);
    send_byte(8'hCC, sc);
    compare_writes("midrst");
    check_regs("midrst");
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    plen   = 4;
    pkt[0] = 8'h01;
    pkt[1] = 8'h00;
    pkt[2] = 8'h05;
    pkt[3] = 8'h66;
    run_packet();
    compare_writes("resume");
    check_regs("resume");

    // random packets against the packet model
    for (int p = 0; p < 40; p++) begin
      plen = $urandom_range(1, 8);
      sel  = $urandom_range(0, 3);
      for (int i = 0; i < plen; i++)
        pkt[i] = 8'($urandom);
      if (sel < 2)
        pkt[0] = 8'h01;
      else if (sel == 2)
        pkt[0] = 8'h02;
      run_packet();
      compare_writes("rnd");
      check_regs("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_cmd_decoder.md
SPI_CMD_DECODER -- requirements
Module: spi_cmd_decoder

Interface
REQ-001 Parameter WIDTH, default 8, SPI byte width; SHALL match the upstream SPI slave's WIDTH.
REQ-002 Parameter ADDR_W, default 16, framebuffer address width.
REQ-003 clk  in  1  system clock; one clock only.
REQ-004 rst  in  1  reset; synchronous and active-high.
REQ-005 cs_n  in  1  SPI chip select, asynchronous to clk, low = packet active.
REQ-006 d_valid  in  1  byte-complete flag from SPI slave, asynchronous to clk.
REQ-007 dout  in  WIDTH  received byte from SPI slave; held stable until the next byte completes.
REQ-008 din  out  WIDTH  response byte to SPI slave; always equals ctrl_reg.
REQ-009 fb_we  out  1  framebuffer write strobe, one clk wide.
REQ-010 fb_addr  out  ADDR_W  framebuffer write address.
REQ-011 fb_wdata  out  WIDTH  framebuffer write data.
REQ-012 ctrl_reg  out  WIDTH  control register for the VGA core.
REQ-013 cmd_err  out  1  sticky flag for an unknown opcode.

Function
REQ-014 d_valid and cs_n SHALL each pass through a 2-flop synchronizer; a rising edge of the synchronized d_valid SHALL produce a one-cycle internal byte strobe that captures dout.
REQ-015 Operating constraint: clk frequency is at least 4x sclk; under this constraint, no byte SHALL be lost.
REQ-016 Latency from the first clk edge that samples d_valid high to fb_we high SHALL be exactly 3 clk cycles.
REQ-017 Opcodes: 0x01 WRITE, 0x02 CTRL; every other value is unknown.
REQ-018 FSM states are IDLE, ADDR_HI, ADDR_LO, DATA, CTRL_DATA and DISCARD.
- IDLE: a byte of 0x01 moves to ADDR_HI; 0x02 moves to CTRL_DATA; any other byte sets cmd_err and moves to DISCARD.
- ADDR_HI: the byte is loaded into address[ADDR_W-1:8]; moves to ADDR_LO.
- ADDR_LO: the byte is loaded into address[7:0]; moves to DATA.
- DATA: each byte produces fb_we with fb_addr equal to the current address and fb_wdata equal to the byte, then address increments by 1; stays in DATA.
- CTRL_DATA: the byte is loaded into ctrl_reg and cmd_err is cleared; moves to DISCARD.
- DISCARD: all further bytes are ignored until cs_n deasserts.
REQ-019 The address counter SHALL wrap modulo 2^ADDR_W: after address 2^ADDR_W-1 the next write goes to 0.
REQ-020 A synchronized cs_n rising edge SHALL return the FSM to IDLE from any state in the following cycle, and SHALL NOT alter ctrl_reg, cmd_err or the address.
REQ-021 If a cs_n rising edge and a byte strobe occur in the same cycle, the byte SHALL be processed first and the FSM SHALL then be in IDLE.
REQ-022 Bytes received while the synchronized cs_n is high SHALL be ignored.
REQ-023 A packet ending in ADDR_HI or ADDR_LO SHALL produce no write.
REQ-024 fb_addr and fb_wdata SHALL be registered and SHALL hold their last values while fb_we is low.

Reset
REQ-025 On rst: FSM = IDLE; fb_we = 0; fb_addr = 0; fb_wdata = 0; ctrl_reg = 0; cmd_err = 0; synchronizer flops = 0 (cs_n synchronizer = 1).
REQ-026 rst asserted mid-packet SHALL abort the packet; after rst releases, decoding SHALL resume only at the next cs_n falling edge followed by an opcode byte.

Structure
REQ-027 Shared package spi_cmd_pkg SHALL hold the opcode constants OP_WRITE and OP_CTRL and the FSM state enum type.
REQ-028 One sub-module sync_2ff (single-bit 2-flop synchronizer, reset value as a parameter) SHALL be instantiated for d_valid and for cs_n.

Verification
REQ-029 Packet 01 12 34 AA BB CC -> fb_we pulses at 0x1234=AA, 0x1235=BB, 0x1236=CC; each fb_we exactly 3 clk after the corresponding d_valid is sampled.
REQ-030 Packet 01 FF FF 11 22 -> writes 0xFFFF=11 then 0x0000=22 (wrap).
REQ-031 Packet 02 5A 77 -> ctrl_reg=5A, din=5A; the 77 byte is ignored; no fb_we.
REQ-032 Packet 7E 01 00 00 33 -> cmd_err=1 and no fb_we; a following packet 02 00 clears cmd_err.
REQ-033 Packet 01 00 (cs_n deasserted), then packet 01 00 10 44 -> exactly one write, 0x0010=44.
REQ-034 rst pulsed after 01 12 34 AA, then bytes BB CC continue in the same packet -> no write from BB or CC; all outputs hold reset values.
